avmm_pio_master: RTL and testbench

Avalon-MM master that drives a register-mapped PIO slave with 32-bit data and a 2-bit word address, such as the team's LED PIO. While enabled, it writes an 8-bit LED pattern to a fixed slave address at a programmable interval. With readback compiled in, it reads the register back and flags mismatches. It sits between board-level control (switch or start logic) and the slave's Avalon-MM port, or beside a soft CPU through an arbiter.

---
 rtl/avmm_pio_master.sv | 154 +++++++++++++++
 tb/tb_avmm_pio_master.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avmm_pio_master.sv
// Avalon-MM master that periodically writes an 8-bit LED pattern to a PIO slave register.
// Optional macro PIO_MASTER_READBACK_EN adds a read-back/compare stage with sticky error tracking.
module avmm_pio_master #(
  parameter int unsigned INTERVAL = 50000000,
  parameter int unsigned CNT_W    = 26,
  parameter logic [1:0]  PIO_ADDR = 2'b00
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        mode,
  input  logic        clear_err,
  output logic [1:0]  m_address,
  output logic        m_write,
  output logic [31:0] m_writedata,
  output logic        m_read,
  input  logic [31:0] m_readdata,
  input  logic        m_waitrequest,
  output logic [7:0]  pattern,
  output logic        busy,
  output logic        error,
  output logic [7:0]  err_count
);

`ifdef PIO_MASTER_READBACK_EN
  typedef enum logic [1:0] {IDLE, WRITE, READ, WAIT} state_t;
`else
  typedef enum logic [1:0] {IDLE, WRITE, WAIT} state_t;
`endif

  localparam logic [CNT_W-1:0] LOAD = CNT_W'(INTERVAL - 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [7:0]       pattern_n;
  logic             mode_q, mode_n;

  function automatic logic [7:0] advance(input logic [7:0] p, input logic walk);
    return walk ? {p[6:0], p[7]} : p + 8'd1;
  endfunction

`ifdef PIO_MASTER_READBACK_EN
  logic rd_accept;
`endif

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    pattern_n = pattern;
    mode_n    = mode_q;
`ifdef PIO_MASTER_READBACK_EN
    rd_accept = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (enable) begin
          mode_n    = mode;
          pattern_n = mode ? 8'h01 : 8'h00;
          state_n   = WRITE;
        end
      end
      WRITE: begin
        if (!m_waitrequest) begin
`ifdef PIO_MASTER_READBACK_EN
          state_n   = READ;
`else
          state_n   = WAIT;
          cnt_n     = LOAD;
          pattern_n = advance(pattern, mode_q);
`endif
        end
      end
`ifdef PIO_MASTER_READBACK_EN
      READ: begin
        if (!m_waitrequest) begin
          rd_accept = 1'b1;
          state_n   = WAIT;
          cnt_n     = LOAD;
          pattern_n = advance(pattern, mode_q);
        end
      end
`endif
      WAIT: begin
        if (cnt != '0) begin
          cnt_n = cnt - 1'b1;
        end else if (enable) begin
          state_n = WRITE;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Request strobes and busy are registered from the next state so they align with it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      mode_q      <= 1'b0;
      pattern     <= '0;
      m_writedata <= '0;
      m_write     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      mode_q      <= mode_n;
      pattern     <= pattern_n;
      m_writedata <= {24'd0, pattern_n};
      m_write     <= (state_n == WRITE);
      busy        <= (state_n != IDLE);
    end
  end

  assign m_address = PIO_ADDR;

`ifdef PIO_MASTER_READBACK_EN
  logic [23:0] unused_readdata;
  assign unused_readdata = m_readdata[31:8];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_read <= 1'b0;
    end else begin
      m_read <= (state_n == READ);
    end
  end

  // clear_err takes priority over a mismatch landing in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      error     <= 1'b0;
      err_count <= '0;
    end else if (clear_err) begin
      error     <= 1'b0;
      err_count <= '0;
    end else if (rd_accept && (m_readdata[7:0] != pattern)) begin
      error <= 1'b1;
      if (err_count != 8'hFF) begin
        err_count <= err_count + 8'd1;
      end
    end
  end
`else
  logic unused_inputs;
  assign unused_inputs = ^{clear_err, m_readdata};
  assign m_read        = 1'b0;
  assign error         = 1'b0;
  assign err_count     = '0;
`endif

endmodule

// File: tb/tb_avmm_pio_master.sv
// Self-checking bench for avmm_pio_master: randomized slave wait states, pattern/timing model,
// readback error tracking (when PIO_MASTER_READBACK_EN is defined) and reset behaviour.
module tb_avmm_pio_master;
  localparam int INTERVAL = 4;
  localparam int CNT_W    = 8;
  localparam logic [1:0] PIO_ADDR = 2'b10;
`ifdef PIO_MASTER_READBACK_EN
  localparam int RB = 1;
`else
  localparam int RB = 0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        mode = 1'b0;
  logic        clear_err = 1'b0;
  logic [1:0]  m_address;
  logic        m_write;
  logic [31:0] m_writedata;
  logic        m_read;
  logic [31:0] m_readdata = '0;
  logic        m_waitrequest = 1'b0;
  logic [7:0]  pattern;
  logic        busy;
  logic        error;
  logic [7:0]  err_count;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // slave model configuration and observations
  int         fixed_waits = 0;
  bit         rand_waits = 1'b0;
  bit         faulty = 1'b0;
  bit         in_txn = 1'b0;
  int         left = 0;
  logic [31:0] txn_data = '0;
  logic [7:0] slave_reg = '0;
  int         wr_start[$];
  logic [7:0] wr_data[$];
  int         wr_waits[$];
  int         rd_waits[$];
  int         wr_acc = 0, rd_acc = 0, stab_err = 0, both_err = 0, addr_err = 0, rd_seen = 0;

  avmm_pio_master #(
    .INTERVAL(INTERVAL),
    .CNT_W(CNT_W),
    .PIO_ADDR(PIO_ADDR)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .enable(enable),
    .mode(mode),
    .clear_err(clear_err),
    .m_address(m_address),
    .m_write(m_write),
    .m_writedata(m_writedata),
    .m_read(m_read),
    .m_readdata(m_readdata),
    .m_waitrequest(m_waitrequest),
    .pattern(pattern),
    .busy(busy),
    .error(error),
    .err_count(err_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave responder: decides stall/accept at the falling edge, DUT samples on the next rise.
  always @(negedge clk) begin
    if (!reset_n) begin
      in_txn = 1'b0;
      m_waitrequest = 1'b0;
    end else begin
      if (m_write && m_read) both_err++;
      if (m_address !== PIO_ADDR) addr_err++;
      if (m_read) rd_seen++;
      if (m_write || m_read) begin
        if (!in_txn) begin
          in_txn = 1'b1;
          txn_data = m_writedata;
          left = rand_waits ? int'($urandom_range(0, 3)) : fixed_waits;
          if (m_write) begin
            wr_start.push_back(cyc);
            wr_waits.push_back(left);
          end else begin
            rd_waits.push_back(left);
          end
        end else if (m_write && (m_writedata !== txn_data)) begin
          stab_err++;
        end
        if (left > 0) begin
          m_waitrequest = 1'b1;
          left--;
        end else begin
          m_waitrequest = 1'b0;
          in_txn = 1'b0;
          if (m_write) begin
            wr_acc++;
            wr_data.push_back(m_writedata[7:0]);
            slave_reg = m_writedata[7:0];
          end else begin
            rd_acc++;
            m_readdata = faulty ? 32'h0000_0055 : {24'd0, slave_reg};
          end
        end
      end else begin
        m_waitrequest = 1'b0;
      end
    end
  end

  task automatic clear_mon();
    wr_start.delete();
    wr_data.delete();
    wr_waits.delete();
    rd_waits.delete();
    wr_acc = 0; rd_acc = 0; stab_err = 0; both_err = 0; addr_err = 0; rd_seen = 0;
  endtask

  task automatic wait_wr(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #2;
      if (wr_acc >= n) begin ok = 1'b1; return; end
    end
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (!busy) begin ok = 1'b1; return; end
    end
  endtask

  task automatic test_reset();
    bit ok;
    repeat (3) @(negedge clk);
    checks++; if (m_write !== 1'b0) begin failures++; $display("FAIL rst_m_write: got %0h expected 0", m_write); end
    checks++; if (m_read !== 1'b0) begin failures++; $display("FAIL rst_m_read: got %0h expected 0", m_read); end
    checks++; if (m_writedata !== 32'h0) begin failures++; $display("FAIL rst_writedata: got %0h expected 0", m_writedata); end
    checks++; if (m_address !== PIO_ADDR) begin failures++; $display("FAIL rst_address: got %0h expected %0h", m_address, PIO_ADDR); end
    checks++; if (pattern !== 8'h00) begin failures++; $display("FAIL rst_pattern: got %0h expected 0", pattern); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %0h expected 0", busy); end
    checks++; if (error !== 1'b0) begin failures++; $display("FAIL rst_error: got %0h expected 0", error); end
    checks++; if (err_count !== 8'h00) begin failures++; $display("FAIL rst_err_count: got %0h expected 0", err_count); end
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0 || m_write !== 1'b0) begin failures++; $display("FAIL idle_after_rst: busy=%0h m_write=%0h expected 0 0", busy, m_write); end
    ok = 1'b1;
  endtask

  task automatic stop_run(input string name);
    bit ok;
    @(negedge clk); enable = 1'b0;
    wait_idle(200, ok);
    checks++; if (!ok) begin failures++; $display("FAIL %s_stop_timeout: busy=%0h expected 0", name, busy); end
  endtask

  task automatic test_count_mode();
    bit ok;
    int gap;
    clear_mon();
    fixed_waits = 0; rand_waits = 1'b0; faulty = 1'b0; mode = 1'b0;
    @(negedge clk); enable = 1'b1;
    @(posedge clk); #1;
    checks++; if (m_write !== 1'b1) begin failures++; $display("FAIL start_latency: m_write=%0h expected 1", m_write); end
    wait_wr(8, 200, ok);
    checks++; if (!ok) begin failures++; $display("FAIL count_timeout: writes=%0d expected 8", wr_acc); end
    if (ok) begin
      for (int k = 0; k < 8; k++) begin
        checks++; if (wr_data[k] !== 8'(k)) begin failures++; $display("FAIL count_data[%0d]: got %0h expected %0h", k, wr_data[k], 8'(k)); end
      end
      for (int k = 0; k < 7; k++) begin
        gap = wr_start[k+1] - wr_start[k];
        checks++; if (gap != INTERVAL + 1 + RB) begin failures++; $display("FAIL count_gap[%0d]: got %0d expected %0d", k, gap, INTERVAL + 1 + RB); end
      end
    end
    stop_run("count");
    checks++; if (both_err != 0 || addr_err != 0) begin failures++; $display("FAIL bus_rules: both=%0d addr=%0d expected 0 0", both_err, addr_err); end
`ifdef PIO_MASTER_READBACK_EN
    checks++; if (rd_acc != wr_acc) begin failures++; $display("FAIL count_reads: got %0d expected %0d", rd_acc, wr_acc); end
    checks++; if (error !== 1'b0) begin failures++; $display("FAIL count_no_error: got %0h expected 0", error); end
`else
    checks++; if (rd_seen != 0) begin failures++; $display("FAIL no_reads: got %0d expected 0", rd_seen); end
`endif
  endtask

  task automatic test_walk_mode();
    bit ok;
    int gap, exp;
    clear_mon();
    rand_waits = 1'b1; faulty = 1'b0; mode = 1'b1;
    @(negedge clk); enable = 1'b1;
    @(posedge clk); #1; mode = 1'b0;
    wait_wr(9, 400, ok);
    checks++; if (!ok) begin failures++; $display("FAIL walk_timeout: writes=%0d expected 9", wr_acc); end
    if (ok) begin
      for (int k = 0; k < 9; k++) begin
        checks++; if (wr_data[k] !== 8'(1 << (k % 8))) begin failures++; $display("FAIL walk_data[%0d]: got %0h expected %0h", k, wr_data[k], 8'(1 << (k % 8))); end
      end
      for (int k = 0; k < 8; k++) begin
        gap = wr_start[k+1] - wr_start[k];
`ifdef PIO_MASTER_READBACK_EN
        exp = INTERVAL + 1 + wr_waits[k] + 1 + rd_waits[k];
`else
        exp = INTERVAL + 1 + wr_waits[k];
`endif
        checks++; if (gap != exp) begin failures++; $display("FAIL walk_gap[%0d]: got %0d expected %0d", k, gap, exp); end
      end
    end
    stop_run("walk");
    rand_waits = 1'b0;
  endtask

  task automatic test_stall();
    bit ok;
    int gap;
    clear_mon();
    fixed_waits = 3; mode = 1'b0;
    @(negedge clk); enable = 1'b1;
    @(posedge clk); #1;
    checks++; if (pattern !== m_writedata[7:0] || m_write !== 1'b1) begin failures++; $display("FAIL stall_pattern_out: pattern=%0h wdata=%0h m_write=%0h", pattern, m_writedata[7:0], m_write); end
    wait_wr(5, 300, ok);
    checks++; if (!ok) begin failures++; $display("FAIL stall_timeout: writes=%0d expected 5", wr_acc); end
    stop_run("stall");
    checks++; if (stab_err != 0) begin failures++; $display("FAIL stall_stable: changes=%0d expected 0", stab_err); end
    checks++; if (wr_acc != wr_start.size()) begin failures++; $display("FAIL stall_one_per_update: accepted=%0d started=%0d", wr_acc, wr_start.size()); end
    for (int k = 0; k < wr_acc; k++) begin
      checks++; if (wr_data[k] !== 8'(k)) begin failures++; $display("FAIL stall_data[%0d]: got %0h expected %0h", k, wr_data[k], 8'(k)); end
    end
    for (int k = 0; k + 1 < wr_start.size(); k++) begin
      gap = wr_start[k+1] - wr_start[k];
      checks++; if (gap != INTERVAL + 4 + 4 * RB) begin failures++; $display("FAIL stall_gap[%0d]: got %0d expected %0d", k, gap, INTERVAL + 4 + 4 * RB); end
    end
    fixed_waits = 0;
  endtask

  task automatic test_enable_drop();
    bit ok;
    clear_mon();
    fixed_waits = 3; mode = 1'b0;
    @(negedge clk); enable = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (wr_start.size() >= 1) ok = 1'b1;
    end
    enable = 1'b0;
    checks++; if (!ok || m_write !== 1'b1) begin failures++; $display("FAIL drop_stalled: m_write=%0h expected 1", m_write); end
    wait_idle(100, ok);
    checks++; if (!ok) begin failures++; $display("FAIL drop_idle_timeout: busy=%0h expected 0", busy); end
    checks++; if (wr_acc != 1) begin failures++; $display("FAIL drop_write_count: got %0d expected 1", wr_acc); end
    checks++; if (m_write !== 1'b0 || m_read !== 1'b0) begin failures++; $display("FAIL drop_quiet: m_write=%0h m_read=%0h expected 0 0", m_write, m_read); end
    checks++; if (pattern !== 8'h01) begin failures++; $display("FAIL drop_pattern: got %0h expected 01", pattern); end
    fixed_waits = 0;
    @(negedge clk); enable = 1'b1;
    wait_wr(2, 50, ok);
    checks++; if (!ok || wr_data[1] !== 8'h00) begin failures++; $display("FAIL restart_data: got %0h expected 00", ok ? wr_data[1] : 8'hxx); end
    stop_run("restart");
  endtask

  task automatic test_readback();
    bit ok;
    clear_mon();
    fixed_waits = 0; faulty = 1'b1; mode = 1'(($urandom & 1));
    @(negedge clk); enable = 1'b1;
`ifdef PIO_MASTER_READBACK_EN
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(posedge clk); #2;
      if (rd_acc >= 1) ok = 1'b1;
    end
    checks++; if (!ok) begin failures++; $display("FAIL rb_first_read_timeout: reads=%0d", rd_acc); end
    checks++; if (error !== 1'b1 || err_count !== 8'h01) begin failures++; $display("FAIL rb_first_error: error=%0h count=%0h expected 1 01", error, err_count); end
    ok = 1'b0;
    for (int i = 0; i < 2500 && !ok; i++) begin
      @(posedge clk); #2;
      if (rd_acc >= 300) ok = 1'b1;
    end
    checks++; if (!ok) begin failures++; $display("FAIL rb_300_timeout: reads=%0d", rd_acc); end
    checks++; if (err_count !== 8'hFF || error !== 1'b1) begin failures++; $display("FAIL rb_saturate: error=%0h count=%0h expected 1 ff", error, err_count); end
    @(negedge clk); clear_err = 1'b1;
    @(negedge clk); clear_err = 1'b0;
    checks++; if (error !== 1'b0 || err_count !== 8'h00) begin failures++; $display("FAIL rb_clear_running: error=%0h count=%0h expected 0 00", error, err_count); end
    stop_run("rb");
    @(negedge clk); clear_err = 1'b1;
    @(negedge clk); clear_err = 1'b0;
    checks++; if (error !== 1'b0 || err_count !== 8'h00) begin failures++; $display("FAIL rb_clear_idle: error=%0h count=%0h expected 0 00", error, err_count); end
`else
    wait_wr(4, 100, ok);
    checks++; if (!ok) begin failures++; $display("FAIL norb_timeout: writes=%0d expected 4", wr_acc); end
    stop_run("norb");
    checks++; if (error !== 1'b0 || err_count !== 8'h00 || rd_seen != 0) begin failures++; $display("FAIL norb_tied: error=%0h count=%0h reads=%0d expected 0 0 0", error, err_count, rd_seen); end
`endif
    faulty = 1'b0;
  endtask

  task automatic test_reset_mid_txn();
    bit ok;
    clear_mon();
    fixed_waits = 3; mode = 1'b1;
    @(negedge clk); enable = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(posedge clk); #2;
`ifdef PIO_MASTER_READBACK_EN
      if (rd_waits.size() >= 1) ok = 1'b1;
`else
      if (wr_start.size() >= 1) ok = 1'b1;
`endif
    end
    checks++; if (!ok || (m_read | m_write) !== 1'b1) begin failures++; $display("FAIL midtxn_stalled: m_write=%0h m_read=%0h expected a request", m_write, m_read); end
    reset_n = 1'b0;
    #1;
    checks++; if (m_read !== 1'b0 || m_write !== 1'b0) begin failures++; $display("FAIL midtxn_drop: m_write=%0h m_read=%0h expected 0 0", m_write, m_read); end
    checks++; if (pattern !== 8'h00 || m_writedata !== 32'h0 || busy !== 1'b0) begin failures++; $display("FAIL midtxn_reset_vals: pattern=%0h wdata=%0h busy=%0h expected 0 0 0", pattern, m_writedata, busy); end
    checks++; if (error !== 1'b0 || err_count !== 8'h00 || m_address !== PIO_ADDR) begin failures++; $display("FAIL midtxn_reset_err: error=%0h count=%0h addr=%0h", error, err_count, m_address); end
    enable = 1'b0; fixed_waits = 0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(posedge clk); #1;
    checks++; if (busy !== 1'b0 || m_write !== 1'b0) begin failures++; $display("FAIL post_reset_idle: busy=%0h m_write=%0h expected 0 0", busy, m_write); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_count_mode();
    test_walk_mode();
    test_stall();
    test_enable_drop();
    test_readback();
    test_reset_mid_txn();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
